mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one physical memory port (pmem) between the instruction-cache miss path and the
//  data-cache miss/writeback path of the pipelined LC-3b core. Grants one requester at a time.
//  Forwards its address, write data and command, then returns the line and a one-cycle resp.
//  Sits between the I-cache/D-cache controllers and main memory; the datapath stalls on the
//  caches while the arbiter serves the other side.
// PARAMETERS
//  ADDR_WIDTH  16   byte address width (lc3b_word)
//  LINE_WIDTH  128  cache line width in bits (one pmem beat)
// PORTS
//  clk          in   1           rising-edge clock
//  rst_n        in   1           asynchronous, active-low reset
//  i_read       in   1           I-side line read request; level, held until i_resp
//  i_address    in   ADDR_WIDTH  I-side line address
//  i_resp       out  1           one-cycle pulse: I-side transaction complete
//  i_rdata      out  LINE_WIDTH  returned line; valid only while i_resp=1
//  d_read       in   1           D-side line read request; level, held until d_resp
//  d_write      in   1           D-side line write (writeback) request; held until d_resp
//  d_address    in   ADDR_WIDTH  D-side line address
//  d_wdata      in   LINE_WIDTH  D-side writeback line
//  d_resp       out  1           one-cycle pulse: D-side transaction complete
//  d_rdata      out  LINE_WIDTH  returned line; valid only while d_resp=1
//  pmem_read    out  1           read command to memory; held until pmem_resp
//  pmem_write   out  1           write command to memory; held until pmem_resp
//  pmem_address out  ADDR_WIDTH  latched granted address
//  pmem_wdata   out  LINE_WIDTH  latched granted write line
//  pmem_rdata   in   LINE_WIDTH  memory read line; valid with pmem_resp
//  pmem_resp    in   1           one-cycle completion pulse from memory
// BEHAVIOUR
//  - States: IDLE, SERVE_I, SERVE_D, DONE. Reset (async, rst_n=0): state=IDLE, all outputs 0.
//    Latched address, wdata and line buffers are 0; last_grant=I.
//  - IDLE: sample requests. If none, stay. A request in cycle N moves to SERVE_x at edge N+1.
//    Address, wdata and cmd latch at that edge. pmem_read/pmem_write are high from cycle N+1.
//  - Fixed priority (default): D beats I when both are pending, so MEM-stage misses are never
//    blocked behind fetch.
//  - D-side with d_read and d_write both high: treated as write.
//  - SERVE_I: pmem_read=1. SERVE_D: pmem_read or pmem_write per the latched cmd.
//    Requester inputs are ignored (not re-sampled) while serving.
//  - On pmem_resp in SERVE_x: latch pmem_rdata (reads only) into the line buffer and go to DONE.
//    pmem_read/pmem_write drop at that edge.
//  - DONE (exactly 1 cycle): the granted side's resp=1 and its rdata=line buffer. The other
//    side's resp=0. Update last_grant. Next state is IDLE unconditionally.
//    This bubble lets the requester drop its request before re-arbitration.
//  - Minimum turnaround: request at N, pmem_resp at N+1+k, resp at N+2+k, next grant at N+4+k.
//  - Any pmem_resp seen in IDLE or DONE is ignored; no outputs change.
//  - i_rdata and d_rdata are driven from the buffer gated by their resp. They are 0 otherwise.
//  - Reset asserted mid-transaction: immediate return to IDLE, commands deassert, no resp.
//    A late pmem_resp is discarded per the rule above.
//  - Width rules: addresses and data pass through unmodified. No alignment checks are made
//    (the caches supply line-aligned addresses).
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin priority. When both sides are pending in IDLE, grant the
//    side opposite last_grant. A lone requester is always granted. Guarantees no side waits
//    more than one foreign transaction.
//  MEM_ARB_RR_EN undefined: fixed D-over-I priority as above. last_grant is still maintained
//    but is unused.
// TESTING
//  1 I-only: i_read=1, i_address=16'h0040; pmem_resp after 3 cycles with rdata=128'hA5..A5
//    -> pmem_read high for 4 cycles, pmem_address=16'h0040, one i_resp pulse with i_rdata=A5..A5.
//  2 D write: d_write=1, d_address=16'h1230, d_wdata=128'h1 -> pmem_write=1, pmem_wdata=128'h1,
//    pmem_read=0. After pmem_resp: one d_resp pulse, d_rdata=0.
//  3 Contention, default build: i_read and d_read rise together, served back-to-back
//    -> D granted first, then I. Check the 1-cycle DONE bubble and 1 IDLE cycle between grants.
//  4 Contention, MEM_ARB_RR_EN: after an I transaction, hold both requests for 3 grants
//    -> grant order D, I, D.
//  5 rst_n pulsed low during SERVE_D -> pmem_write=0 within the same cycle, no d_resp.
//    A pmem_resp 2 cycles later is ignored and state stays IDLE.
//  6 Stray pmem_resp in IDLE with no requests -> i_resp=d_resp=0, pmem_read=pmem_write=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// mem_port_arbiter: shares one pmem port between the I-cache and D-cache miss
// paths. Optional macro MEM_ARB_RR_EN selects round-robin instead of D-first.
// Revision: 1.0
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic                  i_resp,
  output logic [LINE_WIDTH-1:0] i_rdata,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic                  d_resp,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);

`ifdef MEM_ARB_RR_EN
  localparam logic c_rr_en = 1'b1;
`else
  localparam logic c_rr_en = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [LINE_WIDTH-1:0]   wdata_q;
  logic [LINE_WIDTH-1:0]   line_q;
  logic                    last_grant_d_q;
  logic                    pmem_read_q;
  logic                    pmem_write_q;
  logic                    i_resp_q;
  logic                    d_resp_q;
  logic                    d_req;
  logic                    pick_d;

  // With round-robin, D yields only when I is also pending and D won last time.
  always_comb begin
    d_req  = d_read | d_write;
    pick_d = d_req & (~i_read | ~c_rr_en | ~last_grant_d_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      line_q         <= '0;
      last_grant_d_q <= 1'b0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          i_resp_q <= 1'b0;
          d_resp_q <= 1'b0;
          if (pick_d) begin
            state_q      <= SERVE_D;
            addr_q       <= d_address;
            wdata_q      <= d_wdata;
            pmem_write_q <= d_write;
            pmem_read_q  <= ~d_write;
          end else if (i_read) begin
            state_q      <= SERVE_I;
            addr_q       <= i_address;
            wdata_q      <= '0;
            pmem_write_q <= 1'b0;
            pmem_read_q  <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (pmem_resp) begin
            // A writeback returns no line, so the buffer is cleared rather than left stale.
            line_q       <= pmem_read_q ? pmem_rdata : '0;
            pmem_read_q  <= 1'b0;
            pmem_write_q <= 1'b0;
            i_resp_q     <= (state_q == SERVE_I);
            d_resp_q     <= (state_q == SERVE_D);
            state_q      <= DONE;
          end
        end
        DONE: begin
          i_resp_q       <= 1'b0;
          d_resp_q       <= 1'b0;
          last_grant_d_q <= d_resp_q;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = addr_q;
  assign pmem_wdata   = wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign i_rdata      = i_resp_q ? line_q : '0;
  assign d_rdata      = d_resp_q ? line_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_mem_port_arbiter: scoreboard bench; expected grants/responses are queued
// by the stimulus thread and checked by an independent monitor.
// Revision: 1.0
// ============================================================================
module tb_mem_port_arbiter;
  localparam int AW  = 16;
  localparam int LW  = 128;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_address = '0;
  logic          i_resp;
  logic [LW-1:0] i_rdata;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_address = '0;
  logic [LW-1:0] d_wdata = '0;
  logic          d_resp;
  logic [LW-1:0] d_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;

  mem_port_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_address(i_address), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] addr;
    logic [LW-1:0] wdata;
  } gexp_t;

  typedef struct packed {
    logic          is_d;
    logic [LW-1:0] rdata;
  } rexp_t;

  gexp_t gq[$];
  rexp_t rq[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;
  int    grant_cyc = 0;
  int    resp_cyc = 0;
  int    rd_run = 0;
  int    rd_len = 0;
  int    mcnt = 0;
  bit    cmd_prev = 1'b0;
  bit    mem_auto = 1'b1;
  bit    manual_resp = 1'b0;

  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    if (a == 16'h0040) return {16{8'hA5}};
    return {8{a ^ 16'h5A5A}};
  endfunction

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic push_g(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] w);
    gexp_t g;
    g.wr = wr; g.addr = a; g.wdata = w;
    gq.push_back(g);
  endtask

  task automatic push_r(input logic is_d, input logic [LW-1:0] r);
    rexp_t e;
    e.is_d = is_d; e.rdata = r;
    rq.push_back(e);
  endtask

  // Memory model: answers each command on its (LAT+1)-th cycle.
  always @(negedge clk) begin
    if (pmem_read | pmem_write) mcnt++;
    else mcnt = 0;
    pmem_resp  = (mem_auto && (pmem_read | pmem_write) && mcnt == LAT + 1) || manual_resp;
    pmem_rdata = mem_line(pmem_address);
  end

  always @(posedge clk) begin
    gexp_t g;
    rexp_t e;
    bit    cmd_now;
    cyc++;
    #1;
    cmd_now = pmem_read | pmem_write;
    if (cmd_now && !cmd_prev) begin
      grant_cyc = cyc;
      if (gq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_grant: got addr %0h expected no grant", pmem_address);
      end else begin
        g = gq.pop_front();
        check("grant_addr", pmem_address, g.addr);
        check("grant_read", pmem_read, !g.wr);
        check("grant_write", pmem_write, g.wr);
        check("grant_wdata", pmem_wdata, g.wdata);
      end
    end
    if (pmem_read) rd_run++;
    else begin
      if (rd_run != 0) rd_len = rd_run;
      rd_run = 0;
    end
    if (i_resp || d_resp) begin
      resp_cyc = cyc;
      if (rq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_resp: got i_resp=%0b d_resp=%0b expected none", i_resp, d_resp);
      end else begin
        e = rq.pop_front();
        check("resp_i", i_resp, !e.is_d);
        check("resp_d", d_resp, e.is_d);
        check("resp_rdata", e.is_d ? d_rdata : i_rdata, e.rdata);
        check("resp_other_rdata", e.is_d ? i_rdata : d_rdata, '0);
      end
    end else begin
      check("idle_rdata_zero", i_rdata | d_rdata, '0);
    end
    cmd_prev = cmd_now;
  end

  task automatic wait_resp(input bit is_d, input string nm);
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); #2;
      if (is_d ? d_resp : i_resp) return;
    end
    total++; bad++;
    $display("FAIL %s_timeout: got no resp expected resp within 60 cycles", nm);
  endtask

  task automatic stray_resp_pulse();
    @(posedge clk); #2 manual_resp = 1'b1;
    @(posedge clk); #2 manual_resp = 1'b0;
  endtask

  task automatic check_quiet(input string nm, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check(nm, {i_resp, d_resp, pmem_read, pmem_write}, '0);
    end
  endtask

  initial begin
    int t;
    repeat (2) @(negedge clk);
    check("rst_i_resp", i_resp, '0);
    check("rst_d_resp", d_resp, '0);
    check("rst_pmem_read", pmem_read, '0);
    check("rst_pmem_write", pmem_write, '0);
    check("rst_pmem_address", pmem_address, '0);
    check("rst_pmem_wdata", pmem_wdata, '0);
    check("rst_rdata", i_rdata | d_rdata, '0);
    rst_n = 1'b1;
    @(negedge clk);

    // I-only read
    push_g(1'b0, 16'h0040, '0);
    push_r(1'b0, {16{8'hA5}});
    i_read = 1'b1; i_address = 16'h0040;
    wait_resp(1'b0, "t1");
    @(negedge clk); i_read = 1'b0;
    check("t1_read_len", rd_len, 4);
    @(negedge clk);

    // D writeback
    push_g(1'b1, 16'h1230, 128'h1);
    push_r(1'b1, '0);
    d_write = 1'b1; d_address = 16'h1230; d_wdata = 128'h1;
    wait_resp(1'b1, "t2");
    @(negedge clk); d_write = 1'b0; d_wdata = '0;
    @(negedge clk);

`ifdef MEM_ARB_RR_EN
    push_g(1'b0, 16'h0100, '0);
    push_r(1'b0, {8{16'h5B5A}});
    i_read = 1'b1; i_address = 16'h0100;
    wait_resp(1'b0, "t4_pre");
    @(negedge clk); i_read = 1'b0;
    @(negedge clk);
    push_g(1'b0, 16'h3000, '0); push_r(1'b1, {8{16'h6A5A}});
    push_g(1'b0, 16'h0200, '0); push_r(1'b0, {8{16'h585A}});
    push_g(1'b0, 16'h3000, '0); push_r(1'b1, {8{16'h6A5A}});
    d_read = 1'b1; d_address = 16'h3000;
    i_read = 1'b1; i_address = 16'h0200;
    wait_resp(1'b1, "t4_g0");
    wait_resp(1'b0, "t4_g1");
    wait_resp(1'b1, "t4_g2");
    @(negedge clk); d_read = 1'b0; i_read = 1'b0;
    @(negedge clk);
`else
    push_g(1'b0, 16'h2000, '0); push_r(1'b1, {8{16'h7A5A}});
    push_g(1'b0, 16'h0080, '0); push_r(1'b0, {8{16'h5ADA}});
    d_read = 1'b1; d_address = 16'h2000;
    i_read = 1'b1; i_address = 16'h0080;
    wait_resp(1'b1, "t3_d");
    t = resp_cyc;
    @(negedge clk); d_read = 1'b0;
    wait_resp(1'b0, "t3_i");
    check("t3_resp_to_grant_gap", grant_cyc - t, 2);
    @(negedge clk); i_read = 1'b0;
    @(negedge clk);
`endif

    // Reset during SERVE_D
    mem_auto = 1'b0;
    push_g(1'b1, 16'h4440, {4{32'hDEADBEEF}});
    d_write = 1'b1; d_address = 16'h4440; d_wdata = {4{32'hDEADBEEF}};
    for (int k = 0; k < 5 && !pmem_write; k++) @(negedge clk);
    check("t5_in_serve", pmem_write, 1'b1);
    rst_n = 1'b0; d_write = 1'b0;
    #1;
    check("t5_async_write_drop", pmem_write, '0);
    check("t5_no_d_resp", d_resp, '0);
    @(negedge clk); rst_n = 1'b1;
    stray_resp_pulse();
    check_quiet("t5_late_resp_ignored", 3);
    mem_auto = 1'b1;

    // Stray pmem_resp in IDLE
    stray_resp_pulse();
    check_quiet("t6_stray_resp", 3);

    repeat (3) @(negedge clk);
    check("grant_queue_drained", gq.size(), 0);
    check("resp_queue_drained", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
